riscv_alu_issue_stage: RTL and testbench
========================================

Name: riscv_alu_issue_stage

Overview:
Registered issue stage directly upstream of the RISC-V ALU. Accepts one decoded operation per cycle over a valid/ready handshake and resolves operand forwarding from the MEM and WB stages. Selects SrcB between the forwarded register operand and the immediate, and buffers up to two operations in a skid buffer. Drives SrcA, SrcB and ALUControl straight into the ALU inputs, so ALU backpressure never combinationally reaches the decode stage.

Parameters:
DATA_W, 32, operand/result width
REG_AW, 5, register-address width

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
Flush  input  1  discard all buffered ops (branch/jump redirect)
InValid  input  1  decoded op present
InReady  output  1  stage can accept an op this cycle
RD1  input  DATA_W  register-file read data, rs1
RD2  input  DATA_W  register-file read data, rs2
ImmExt  input  DATA_W  sign-extended immediate
ALUSrc  input  1  1: SrcB=ImmExt; 0: SrcB=forwarded rs2
ALUControlIn  input  3  ALU opcode
Rs1  input  REG_AW  source register 1
Rs2  input  REG_AW  source register 2
RdIn  input  REG_AW  destination register
RegWriteIn  input  1  op writes the register file
FwdMemEn  input  1  MEM-stage result valid for forwarding
FwdMemRd  input  REG_AW  MEM-stage destination
FwdMemData  input  DATA_W  MEM-stage result
FwdWbEn  input  1  WB-stage result valid
FwdWbRd  input  REG_AW  WB-stage destination
FwdWbData  input  DATA_W  WB-stage result
OutValid  output  1  SrcA/SrcB/ALUControl hold a valid op
OutReady  input  1  ALU/EX register consumes the op
SrcA  output  DATA_W  ALU operand A
SrcB  output  DATA_W  ALU operand B
ALUControl  output  3  ALU opcode
WriteData  output  DATA_W  forwarded rs2 (store data)
RdOut  output  REG_AW  destination register
RegWriteOut  output  1  register-write enable
IllegalOp  output  1  sticky illegal-opcode flag (optional feature)

Behaviour:
- Clocking: single clock domain on clk; reset is synchronous and active-high.
- Reset: OutValid=0, SrcA=SrcB=WriteData=0, ALUControl=0, RdOut=0, RegWriteOut=0, IllegalOp=0, skid entry empty. InReady=1 from the first cycle after reset.
- Accept condition: InValid && InReady. Output handshake: OutValid && OutReady.
- Forwarding is resolved at accept time, per source s in {Rs1, Rs2}:
  - if FwdMemEn && FwdMemRd==s && s!=0, use FwdMemData;
  - else if FwdWbEn && FwdWbRd==s && s!=0, use FwdWbData;
  - else use RDx.
  - MEM has priority over WB. Register x0 is never forwarded.
  - Once captured, an op's operands are not re-forwarded; the hazard unit guarantees correctness while the op is buffered.
- Operand select: SrcB = ALUSrc ? ImmExt : fwd_rs2. WriteData = fwd_rs2 always. SrcA = fwd_rs1.
- Storage: a main output register plus one skid register. InReady = !skid_valid, driven from a register (no combinational path from OutReady).
- Latency: an op accepted in cycle N appears on the outputs in N+1 if the main register is empty or is consumed in N. Otherwise it goes to the skid register and moves to main on the first cycle main is consumed.
- Throughput: 1 op/cycle. Strict FIFO order.
- Full: both entries valid gives InReady=0. Any InValid is ignored and must be held by upstream.
- Simultaneous accept and consume with skid empty: main is loaded with the new op and OutValid stays 1.
- Flush: next cycle OutValid=0, skid empty, InReady=1. Flush has priority over a same-cycle accept (the incoming op is dropped) and over consume. IllegalOp is unaffected.
- Reset mid-operation: all ops are discarded exactly as at reset.
- Output data fields hold their last value while OutValid=0. The consumer must ignore them.

Optional Feature:
Macro RISCV_ALU_ILLEGAL_OP_EN.
- Defined: ALUControlIn==3'b011 (not implemented by the ALU) is still accepted but never issued. The op is dropped and IllegalOp is set and held until reset.
- Not defined: 3'b011 passes through like any opcode, and IllegalOp is tied to 0. The port exists in both builds.

Test Plan:
- Reset, then InValid=1 with Rs1=3, RD1=5, RD2=7, ALUSrc=0, ALUControlIn=000, OutReady=1 -> next cycle OutValid=1, SrcA=5, SrcB=7, ALUControl=000. InReady stays 1.
- Rs1=4; FwdMemEn=1, FwdMemRd=4, FwdMemData=0xAA; FwdWbEn=1, FwdWbRd=4, FwdWbData=0xBB -> SrcA=0xAA. With Rs1=0, FwdMemRd=0 -> SrcA=RD1 (no forwarding).
- ALUSrc=1, ImmExt=0xFFFFFFFC, Rs2 forwarded from WB=0x10 -> SrcB=0xFFFFFFFC, WriteData=0x10.
- OutReady=0, push ops A, B, C back-to-back -> A on outputs; B taken into skid; InReady=0 in the cycle after B is taken, so C is not accepted until OutReady rises. Then OutReady=1 -> outputs A, B, C in consecutive cycles.
- Two entries buffered, Flush=1 with InValid=1 -> next cycle OutValid=0, InReady=1, and no op ever emerges.
- With the macro defined, op ALUControlIn=011 followed by op 000 -> only 000 is issued and IllegalOp=1 sticky. Without the macro, 011 is issued and IllegalOp=0.

Source files
------------

// File: rtl/riscv_alu_issue_stage.sv
// Registered ALU issue stage: MEM/WB operand forwarding, SrcB select, 2-entry skid buffer.
// Optional: define RISCV_ALU_ILLEGAL_OP_EN to drop opcode 3'b011 and raise a sticky IllegalOp.
module riscv_alu_issue_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Flush,
  input  logic              InValid,
  output logic              InReady,
  input  logic [DATA_W-1:0] RD1,
  input  logic [DATA_W-1:0] RD2,
  input  logic [DATA_W-1:0] ImmExt,
  input  logic              ALUSrc,
  input  logic [2:0]        ALUControlIn,
  input  logic [REG_AW-1:0] Rs1,
  input  logic [REG_AW-1:0] Rs2,
  input  logic [REG_AW-1:0] RdIn,
  input  logic              RegWriteIn,
  input  logic              FwdMemEn,
  input  logic [REG_AW-1:0] FwdMemRd,
  input  logic [DATA_W-1:0] FwdMemData,
  input  logic              FwdWbEn,
  input  logic [REG_AW-1:0] FwdWbRd,
  input  logic [DATA_W-1:0] FwdWbData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] SrcA,
  output logic [DATA_W-1:0] SrcB,
  output logic [2:0]        ALUControl,
  output logic [DATA_W-1:0] WriteData,
  output logic [REG_AW-1:0] RdOut,
  output logic              RegWriteOut,
  output logic              IllegalOp
);

  typedef struct packed {
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic [DATA_W-1:0] wdata;
    logic [2:0]        alu_ctl;
    logic [REG_AW-1:0] rd;
    logic              reg_wr;
  } op_t;

  op_t               main_q, skid_q, new_op;
  logic              main_vld, skid_vld;
  logic              accept, consume, issue, drop;
  logic [DATA_W-1:0] fwd_rs1, fwd_rs2;

  // x0 is hardwired, so it must never pick up a forwarded value
  always_comb begin
    fwd_rs1 = RD1;
    if (FwdMemEn && FwdMemRd == Rs1 && Rs1 != '0)     fwd_rs1 = FwdMemData;
    else if (FwdWbEn && FwdWbRd == Rs1 && Rs1 != '0)  fwd_rs1 = FwdWbData;
    fwd_rs2 = RD2;
    if (FwdMemEn && FwdMemRd == Rs2 && Rs2 != '0)     fwd_rs2 = FwdMemData;
    else if (FwdWbEn && FwdWbRd == Rs2 && Rs2 != '0)  fwd_rs2 = FwdWbData;
  end

  always_comb begin
    new_op         = '0;
    new_op.src_a   = fwd_rs1;
    new_op.src_b   = ALUSrc ? ImmExt : fwd_rs2;
    new_op.wdata   = fwd_rs2;
    new_op.alu_ctl = ALUControlIn;
    new_op.rd      = RdIn;
    new_op.reg_wr  = RegWriteIn;
  end

  // Ready depends only on skid occupancy, so ALU stalls never reach decode combinationally
  assign InReady = !skid_vld;
  assign accept  = InValid && InReady;
  assign consume = main_vld && OutReady;
  assign issue   = accept && !drop;

`ifdef RISCV_ALU_ILLEGAL_OP_EN
  logic illegal_q;
  assign drop      = (ALUControlIn == 3'b011);
  assign IllegalOp = illegal_q;
  always_ff @(posedge clk) begin
    if (reset)                         illegal_q <= 1'b0;
    else if (accept && drop && !Flush) illegal_q <= 1'b1;
  end
`else
  assign drop      = 1'b0;
  assign IllegalOp = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else if (Flush) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (!main_vld || consume) begin
      // Skid full implies no accept this cycle, so skid drains first to keep FIFO order
      if (skid_vld) begin
        main_q   <= skid_q;
        main_vld <= 1'b1;
        skid_vld <= 1'b0;
      end else if (issue) begin
        main_q   <= new_op;
        main_vld <= 1'b1;
      end else begin
        main_vld <= 1'b0;
      end
    end else if (issue) begin
      skid_q   <= new_op;
      skid_vld <= 1'b1;
    end
  end

  assign OutValid    = main_vld;
  assign SrcA        = main_q.src_a;
  assign SrcB        = main_q.src_b;
  assign ALUControl  = main_q.alu_ctl;
  assign WriteData   = main_q.wdata;
  assign RdOut       = main_q.rd;
  assign RegWriteOut = main_q.reg_wr;

endmodule

// File: tb/tb_riscv_alu_issue_stage.sv
// Directed bench for riscv_alu_issue_stage: forwarding, operand select, skid ordering, flush, reset.
module tb_riscv_alu_issue_stage;
  logic        clk = 1'b0;
  logic        reset, Flush, InValid, InReady;
  logic [31:0] RD1, RD2, ImmExt;
  logic        ALUSrc;
  logic [2:0]  ALUControlIn;
  logic [4:0]  Rs1, Rs2, RdIn;
  logic        RegWriteIn;
  logic        FwdMemEn, FwdWbEn;
  logic [4:0]  FwdMemRd, FwdWbRd;
  logic [31:0] FwdMemData, FwdWbData;
  logic        OutValid, OutReady;
  logic [31:0] SrcA, SrcB, WriteData;
  logic [2:0]  ALUControl;
  logic [4:0]  RdOut;
  logic        RegWriteOut, IllegalOp;

  int checks = 0;
  int passed = 0;

  riscv_alu_issue_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .Flush(Flush), .InValid(InValid), .InReady(InReady),
    .RD1(RD1), .RD2(RD2), .ImmExt(ImmExt), .ALUSrc(ALUSrc), .ALUControlIn(ALUControlIn),
    .Rs1(Rs1), .Rs2(Rs2), .RdIn(RdIn), .RegWriteIn(RegWriteIn),
    .FwdMemEn(FwdMemEn), .FwdMemRd(FwdMemRd), .FwdMemData(FwdMemData),
    .FwdWbEn(FwdWbEn), .FwdWbRd(FwdWbRd), .FwdWbData(FwdWbData),
    .OutValid(OutValid), .OutReady(OutReady), .SrcA(SrcA), .SrcB(SrcB),
    .ALUControl(ALUControl), .WriteData(WriteData), .RdOut(RdOut),
    .RegWriteOut(RegWriteOut), .IllegalOp(IllegalOp)
  );

  always #5 clk = ~clk;

  // advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic op(input logic [4:0] rs1, input logic [31:0] rd1, input logic [4:0] rs2,
                    input logic [31:0] rd2, input logic [2:0] ctl);
    InValid = 1'b1; Rs1 = rs1; RD1 = rd1; Rs2 = rs2; RD2 = rd2; ALUControlIn = ctl;
  endtask

  initial begin
    reset = 1'b1; Flush = 1'b0; InValid = 1'b0; RD1 = '0; RD2 = '0; ImmExt = '0;
    ALUSrc = 1'b0; ALUControlIn = '0; Rs1 = '0; Rs2 = '0; RdIn = '0; RegWriteIn = 1'b0;
    FwdMemEn = 1'b0; FwdWbEn = 1'b0; FwdMemRd = '0; FwdWbRd = '0;
    FwdMemData = '0; FwdWbData = '0; OutReady = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("rst_outvalid", {31'b0, OutValid}, 32'd0);
    chk("rst_srca", SrcA, 32'd0);
    chk("rst_srcb", SrcB, 32'd0);
    chk("rst_ctl", {29'b0, ALUControl}, 32'd0);
    chk("rst_inready", {31'b0, InReady}, 32'd1);
    chk("rst_illegal", {31'b0, IllegalOp}, 32'd0);

    // basic issue, no forwarding
    OutReady = 1'b1; RdIn = 5'd9; RegWriteIn = 1'b1;
    op(5'd3, 32'd5, 5'd2, 32'd7, 3'b000);
    step();
    InValid = 1'b0;
    chk("basic_valid", {31'b0, OutValid}, 32'd1);
    chk("basic_srca", SrcA, 32'd5);
    chk("basic_srcb", SrcB, 32'd7);
    chk("basic_wdata", WriteData, 32'd7);
    chk("basic_rd", {27'b0, RdOut}, 32'd9);
    chk("basic_regwr", {31'b0, RegWriteOut}, 32'd1);
    chk("basic_inready", {31'b0, InReady}, 32'd1);
    step();
    chk("basic_consumed", {31'b0, OutValid}, 32'd0);
    chk("hold_srca", SrcA, 32'd5);

    // MEM beats WB for the same register
    FwdMemEn = 1'b1; FwdMemRd = 5'd4; FwdMemData = 32'hAA;
    FwdWbEn = 1'b1; FwdWbRd = 5'd4; FwdWbData = 32'hBB;
    op(5'd4, 32'h11, 5'd5, 32'h22, 3'b010);
    step();
    chk("fwd_mem_srca", SrcA, 32'hAA);
    chk("fwd_nohit_srcb", SrcB, 32'h22);
    chk("fwd_ctl", {29'b0, ALUControl}, 32'd2);
    // WB only; simultaneous accept+consume keeps OutValid high
    FwdMemEn = 1'b0;
    op(5'd4, 32'h11, 5'd5, 32'h22, 3'b001);
    step();
    chk("fwd_wb_srca", SrcA, 32'hBB);
    chk("b2b_valid", {31'b0, OutValid}, 32'd1);
    // x0 never forwarded
    FwdMemEn = 1'b1; FwdMemRd = 5'd0; FwdWbRd = 5'd0;
    op(5'd0, 32'h33, 5'd0, 32'h44, 3'b000);
    step();
    chk("x0_srca", SrcA, 32'h33);
    chk("x0_wdata", WriteData, 32'h44);

    // immediate select, store data from WB forward
    FwdMemEn = 1'b0; FwdWbEn = 1'b1; FwdWbRd = 5'd6; FwdWbData = 32'h10;
    ALUSrc = 1'b1; ImmExt = 32'hFFFFFFFC;
    op(5'd1, 32'h1, 5'd6, 32'h99, 3'b000);
    step();
    chk("imm_srcb", SrcB, 32'hFFFFFFFC);
    chk("imm_wdata", WriteData, 32'h10);
    InValid = 1'b0; ALUSrc = 1'b0; FwdWbEn = 1'b0;
    step();
    chk("idle_valid", {31'b0, OutValid}, 32'd0);

    // backpressure: A, B, C with OutReady low
    OutReady = 1'b0;
    op(5'd1, 32'hA, 5'd2, 32'h0, 3'b000);
    step();
    chk("bp_a_out", SrcA, 32'hA);
    chk("bp_a_ready", {31'b0, InReady}, 32'd1);
    op(5'd1, 32'hB, 5'd2, 32'h0, 3'b000);
    step();
    chk("bp_b_skid_ready", {31'b0, InReady}, 32'd0);
    chk("bp_b_hold_a", SrcA, 32'hA);
    op(5'd1, 32'hC, 5'd2, 32'h0, 3'b000);
    step(); step();
    chk("bp_c_held_ready", {31'b0, InReady}, 32'd0);
    chk("bp_c_held_a", SrcA, 32'hA);
    OutReady = 1'b1;
    step();
    chk("drain_b", SrcA, 32'hB);
    chk("drain_b_valid", {31'b0, OutValid}, 32'd1);
    chk("drain_ready", {31'b0, InReady}, 32'd1);
    step();
    InValid = 1'b0;
    chk("drain_c", SrcA, 32'hC);
    chk("drain_c_valid", {31'b0, OutValid}, 32'd1);
    step();
    chk("drain_empty", {31'b0, OutValid}, 32'd0);

    // flush with both entries full
    OutReady = 1'b0;
    op(5'd1, 32'hD, 5'd2, 32'h0, 3'b000); step();
    op(5'd1, 32'hE, 5'd2, 32'h0, 3'b000); step();
    chk("fl_full", {31'b0, InReady}, 32'd0);
    Flush = 1'b1; op(5'd1, 32'hF, 5'd2, 32'h0, 3'b000);
    step();
    Flush = 1'b0; InValid = 1'b0;
    chk("fl_valid", {31'b0, OutValid}, 32'd0);
    chk("fl_ready", {31'b0, InReady}, 32'd1);
    OutReady = 1'b1;
    step();
    chk("fl_no_emerge", {31'b0, OutValid}, 32'd0);
    // flush beats a same-cycle accept into an empty skid
    OutReady = 1'b0;
    op(5'd1, 32'h12, 5'd2, 32'h0, 3'b000); step();
    Flush = 1'b1; op(5'd1, 32'h13, 5'd2, 32'h0, 3'b000);
    step();
    Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    chk("fl_acc_valid", {31'b0, OutValid}, 32'd0);
    step();
    chk("fl_acc_drop", {31'b0, OutValid}, 32'd0);

    // illegal opcode handling
    op(5'd1, 32'h21, 5'd2, 32'h0, 3'b011);
    step();
`ifdef RISCV_ALU_ILLEGAL_OP_EN
    chk("ill_dropped", {31'b0, OutValid}, 32'd0);
    chk("ill_flag", {31'b0, IllegalOp}, 32'd1);
`else
    chk("ill_issued", {31'b0, OutValid}, 32'd1);
    chk("ill_ctl", {29'b0, ALUControl}, 32'd3);
    chk("ill_flag", {31'b0, IllegalOp}, 32'd0);
`endif
    op(5'd1, 32'h22, 5'd2, 32'h0, 3'b000);
    step();
    InValid = 1'b0;
    chk("ill_next_valid", {31'b0, OutValid}, 32'd1);
    chk("ill_next_srca", SrcA, 32'h22);
`ifdef RISCV_ALU_ILLEGAL_OP_EN
    chk("ill_sticky", {31'b0, IllegalOp}, 32'd1);
`else
    chk("ill_sticky", {31'b0, IllegalOp}, 32'd0);
`endif

    // reset mid-operation with both entries full
    OutReady = 1'b0;
    op(5'd1, 32'h31, 5'd2, 32'h0, 3'b000); step();
    op(5'd1, 32'h32, 5'd2, 32'h0, 3'b000); step();
    InValid = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0; OutReady = 1'b1;
    chk("mrst_valid", {31'b0, OutValid}, 32'd0);
    chk("mrst_ready", {31'b0, InReady}, 32'd1);
    chk("mrst_srca", SrcA, 32'd0);
    chk("mrst_illegal", {31'b0, IllegalOp}, 32'd0);
    step();
    chk("mrst_no_emerge", {31'b0, OutValid}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
